cxu_initiator: RTL and testbench
================================

CXU_INITIATOR -- requirements
Module: cxu_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the cycles allowed from entering ISSUE until a response before a timeout error.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid / req_ready  input / output  1 / 1  host command handshake.
REQ-005 req_function_id  input  3; req_state_id  input  3; req_cxu_id  input  4  command selectors.
REQ-006 req_inputs_0, req_inputs_1  input  32 each  operands.
REQ-007 cmd_valid / cmd_ready  output / input  1 / 1  CXU command handshake.
REQ-008 cmd_payload_function_id 3, cmd_payload_inputs_0 32, cmd_payload_inputs_1 32, cmd_payload_state_id 3, cmd_payload_cxu_id 4  outputs  latched command fields.
REQ-009 rsp_valid / rsp_ready  input / output  1 / 1  CXU response handshake; rsp_payload_outputs_0  input  32  result.
REQ-010 res_valid / res_ready  output / input  1 / 1  host result handshake; res_data  output  32; res_error  output  1  timeout flag.
REQ-011 done_count, err_count  output  16 each  completed-command and timeout counters.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, WAIT, DELIVER; only one command SHALL be outstanding.
REQ-013 IDLE: req_ready=1; on req_valid&req_ready, all req_* fields latched into cmd_payload_* registers, timeout counter cleared, next state ISSUE.
REQ-014 ISSUE: cmd_valid=1, payload held stable until cmd_ready; rsp_ready=1.
REQ-015 ISSUE with cmd_ready=1 and rsp_valid=0: next state WAIT.
REQ-016 ISSUE with cmd_ready=1 and rsp_valid=1 in the same cycle (combinational responder): rsp_payload_outputs_0 captured into res_data, res_error=0, next state DELIVER; minimum latency req accept -> res_valid is 2 cycles.
REQ-017 A response with rsp_valid=1 in ISSUE while cmd_ready=0 SHALL be ignored.
REQ-018 WAIT: rsp_ready=1, cmd_valid=0; on rsp_valid, capture rsp_payload_outputs_0 into res_data, res_error=0, next state DELIVER.
REQ-019 The timeout counter SHALL increment each cycle in ISSUE or WAIT; when it equals TIMEOUT_CYCLES with no response captured that cycle, res_data=32'h0, res_error=1, cmd_valid deasserted, next state DELIVER.
REQ-020 Response capture SHALL take priority over timeout in the same cycle.
REQ-021 DELIVER: res_valid=1, res_data/res_error held stable; on res_ready, next state IDLE; req_ready=0.
REQ-022 In IDLE and DELIVER, rsp_ready=1 and any rsp_valid SHALL be discarded without affecting res_data (drains late responses after timeout).
REQ-023 done_count SHALL increment on each DELIVER->IDLE with res_error=0; err_count on each with res_error=1; both saturate at 16'hFFFF.
REQ-024 req_ready, cmd_valid, res_valid SHALL be mutually exclusive.

Reset
REQ-025 reset=1 SHALL force state IDLE and, from the next cycle: cmd_valid=0, res_valid=0, res_error=0, res_data=0, all cmd_payload_*=0, timeout counter=0, done_count=0, err_count=0, req_ready=1, rsp_ready=1.
REQ-026 Reset asserted in ISSUE/WAIT/DELIVER SHALL abandon the command with no result delivered and no counter update.

Verification
REQ-027 Combinational responder (cmd_ready=1, rsp_valid=1, out=inputs_0*inputs_1): req 3,5, res_ready=1 -> res_valid 2 cycles after accept, res_data=15, res_error=0, done_count=1.
REQ-028 cmd_ready held 0 for 4 cycles then 1, response 3 cycles later with 32'hDEADBEEF -> payload stable throughout ISSUE, res_data=32'hDEADBEEF.
REQ-029 TIMEOUT_CYCLES=8, responder never responds -> res_valid with res_error=1, res_data=0 after 8 cycles in ISSUE/WAIT; err_count=1; later rsp_valid in IDLE discarded.
REQ-030 res_ready held 0 for 10 cycles in DELIVER -> res_valid, res_data stable; req_ready=0; new req_valid not accepted.
REQ-031 reset pulsed in WAIT -> next cycle IDLE, cmd_valid=0, res_valid=0, counters 0; following req completes normally.
REQ-032 Response and timeout in the same cycle -> res_error=0, response data delivered, done_count increments.

Source files
------------

// File: rtl/cxu_initiator.sv
// Host-to-CXU command initiator: latches one host command, issues it to the CXU,
// waits for a response or timeout, then hands the result back to the host.
//
//   state      | meaning
//   ST_IDLE    | ready for a host command
//   ST_ISSUE   | command presented to CXU, awaiting cmd_ready
//   ST_WAIT    | command taken, awaiting response
//   ST_DELIVER | result presented to host
module cxu_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_function_id,
    input  logic [2:0]  req_state_id,
    input  logic [3:0]  req_cxu_id,
    input  logic [31:0] req_inputs_0,
    input  logic [31:0] req_inputs_1,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_payload_function_id,
    output logic [31:0] cmd_payload_inputs_0,
    output logic [31:0] cmd_payload_inputs_1,
    output logic [2:0]  cmd_payload_state_id,
    output logic [3:0]  cmd_payload_cxu_id,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_payload_outputs_0,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_error,
    output logic [15:0] done_count,
    output logic [15:0] err_count
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELIVER
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic [2:0]    r_function_id;
    logic [2:0]    r_state_id;
    logic [3:0]    r_cxu_id;
    logic [31:0]   r_inputs_0;
    logic [31:0]   r_inputs_1;
    logic [31:0]   r_res_data;
    logic          r_res_error;
    logic [15:0]   r_done_cnt;
    logic [15:0]   r_err_cnt;

    logic w_accept;
    logic w_capture;
    logic w_timeout;
    logic w_retire;
    logic w_tmo_hit;

    // The counter holds the number of already-elapsed ISSUE/WAIT cycles, so the
    // last allowed cycle is the one where it reads TIMEOUT_CYCLES-1.
    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready && rsp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DELIVER;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DELIVER;
                end else if (cmd_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DELIVER;
                end else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (res_ready) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_tmo_cnt     <= '0;
            r_function_id <= '0;
            r_state_id    <= '0;
            r_cxu_id      <= '0;
            r_inputs_0    <= '0;
            r_inputs_1    <= '0;
            r_res_data    <= '0;
            r_res_error   <= 1'b0;
            r_done_cnt    <= '0;
            r_err_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_function_id <= req_function_id;
                r_state_id    <= req_state_id;
                r_cxu_id      <= req_cxu_id;
                r_inputs_0    <= req_inputs_0;
                r_inputs_1    <= req_inputs_1;
                r_tmo_cnt     <= '0;
            end else if (r_state == ST_ISSUE || r_state == ST_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
            if (w_capture) begin
                r_res_data  <= rsp_payload_outputs_0;
                r_res_error <= 1'b0;
            end else if (w_timeout) begin
                r_res_data  <= '0;
                r_res_error <= 1'b1;
            end
            if (w_retire) begin
                if (r_res_error) begin
                    if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                end else begin
                    if (r_done_cnt != 16'hFFFF) r_done_cnt <= r_done_cnt + 16'd1;
                end
            end
        end
    end

    assign req_ready               = (r_state == ST_IDLE);
    assign cmd_valid               = (r_state == ST_ISSUE);
    assign res_valid               = (r_state == ST_DELIVER);
    assign rsp_ready               = 1'b1;
    assign cmd_payload_function_id = r_function_id;
    assign cmd_payload_state_id    = r_state_id;
    assign cmd_payload_cxu_id      = r_cxu_id;
    assign cmd_payload_inputs_0    = r_inputs_0;
    assign cmd_payload_inputs_1    = r_inputs_1;
    assign res_data                = r_res_data;
    assign res_error               = r_res_error;
    assign done_count              = r_done_cnt;
    assign err_count               = r_err_cnt;

endmodule

// File: tb/tb_cxu_initiator.sv
// Bench for cxu_initiator: per-command outcome predicted from the responder
// schedule (first command handshake, first usable response, timeout limit).
module tb_cxu_initiator;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_function_id;
    logic [2:0]  req_state_id;
    logic [3:0]  req_cxu_id;
    logic [31:0] req_inputs_0;
    logic [31:0] req_inputs_1;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic [2:0]  cmd_payload_state_id;
    logic [3:0]  cmd_payload_cxu_id;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_error;
    logic [15:0] done_count;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    cxu_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_function_id         (req_function_id),
        .req_state_id            (req_state_id),
        .req_cxu_id              (req_cxu_id),
        .req_inputs_0            (req_inputs_0),
        .req_inputs_1            (req_inputs_1),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .cmd_payload_state_id    (cmd_payload_state_id),
        .cmd_payload_cxu_id      (cmd_payload_cxu_id),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .res_valid               (res_valid),
        .res_ready               (res_ready),
        .res_data                (res_data),
        .res_error               (res_error),
        .done_count              (done_count),
        .err_count               (err_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_done;
    logic [15:0] m_err;
    logic [31:0] m_last_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_ready", rsp_ready, 1);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_error", res_error, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_pay_in0", cmd_payload_inputs_0, 0);
        chk("rst_pay_in1", cmd_payload_inputs_1, 0);
        chk("rst_pay_ids", {cmd_payload_function_id, cmd_payload_state_id, cmd_payload_cxu_id}, 0);
        chk("rst_done", done_count, 0);
        chk("rst_err", err_count, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_req_ready", req_ready, 1);
            chk("idle_cmd_valid", cmd_valid, 0);
            chk("idle_res_valid", res_valid, 0);
            chk("idle_rsp_ready", rsp_ready, 1);
            chk("idle_res_data", res_data, m_last_res);
            req_valid             = 1'b0;
            rsp_valid             = 1'($urandom_range(0, 1));
            rsp_payload_outputs_0 = $urandom;
            cmd_ready             = 1'($urandom_range(0, 1));
            res_ready             = 1'($urandom_range(0, 1));
        end
    endtask

    // mode 0 random responder, 1 combinational multiplier, 2 stalled cmd_ready
    // then late DEADBEEF, 3 silent responder, 4 response exactly at the limit
    task automatic run_txn(input int mode, input int hold, input bit fixed_ab,
                           input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b, exp_data;
        logic [2:0]  f, s;
        logic [3:0]  c;
        bit          cr [T+1];
        bit          rv [T+1];
        logic [31:0] rd [T+1];
        int          k_cmd, k_end;
        bit          err;

        a = fixed_ab ? a_in : $urandom;
        b = fixed_ab ? b_in : $urandom;
        f = 3'($urandom);
        s = 3'($urandom);
        c = 4'($urandom);
        for (int k = 1; k <= T; k++) begin
            rd[k] = $urandom;
            case (mode)
                1: begin cr[k] = 1; rv[k] = 1; rd[k] = a * b; end
                2: begin
                    cr[k] = (k >= 5);
                    rv[k] = (k < 4) || (k == 8);
                    if (k == 8) rd[k] = 32'hDEADBEEF;
                end
                3: begin cr[k] = 1; rv[k] = 0; end
                4: begin cr[k] = 1; rv[k] = (k == T); end
                default: begin
                    cr[k] = ($urandom_range(0, 2) == 0);
                    rv[k] = ($urandom_range(0, 3) == 0);
                end
            endcase
        end

        k_cmd = T + 1;
        for (int k = 1; k <= T; k++) if (cr[k]) begin k_cmd = k; break; end
        k_end = 0;
        for (int k = k_cmd; k <= T; k++) if (rv[k]) begin k_end = k; break; end
        if (k_end == 0) begin
            k_end = T; err = 1; exp_data = 0;
        end else begin
            err = 0; exp_data = rd[k_end];
        end

        @(negedge clk);
        chk("acc_req_ready", req_ready, 1);
        req_valid             = 1'b1;
        req_function_id       = f;
        req_state_id          = s;
        req_cxu_id            = c;
        req_inputs_0          = a;
        req_inputs_1          = b;
        rsp_valid             = 1'($urandom_range(0, 1));
        rsp_payload_outputs_0 = $urandom;
        cmd_ready             = 1'($urandom_range(0, 1));
        res_ready             = 1'b0;

        for (int k = 1; k <= k_end; k++) begin
            @(negedge clk);
            chk("busy_cmd_valid", cmd_valid, (k <= k_cmd) ? 1 : 0);
            chk("busy_req_ready", req_ready, 0);
            chk("busy_res_valid", res_valid, 0);
            chk("busy_rsp_ready", rsp_ready, 1);
            chk("pay_in0", cmd_payload_inputs_0, a);
            chk("pay_in1", cmd_payload_inputs_1, b);
            chk("pay_ids", {cmd_payload_function_id, cmd_payload_state_id, cmd_payload_cxu_id}, {f, s, c});
            req_valid             = 1'($urandom_range(0, 1));
            req_inputs_0          = $urandom;
            req_inputs_1          = $urandom;
            cmd_ready             = cr[k];
            rsp_valid             = rv[k];
            rsp_payload_outputs_0 = rd[k];
            res_ready             = 1'($urandom_range(0, 1));
        end

        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            chk("dlv_res_valid", res_valid, 1);
            chk("dlv_res_data", res_data, exp_data);
            chk("dlv_res_error", res_error, err);
            chk("dlv_req_ready", req_ready, 0);
            chk("dlv_cmd_valid", cmd_valid, 0);
            chk("dlv_pay_in0", cmd_payload_inputs_0, a);
            res_ready             = (h == hold);
            rsp_valid             = 1'($urandom_range(0, 1));
            rsp_payload_outputs_0 = $urandom;
            req_valid             = 1'($urandom_range(0, 1));
            req_inputs_0          = $urandom;
            cmd_ready             = 1'($urandom_range(0, 1));
        end

        if (err) m_err = m_err + 1;
        else     m_done = m_done + 1;
        m_last_res = exp_data;

        @(negedge clk);
        chk("post_req_ready", req_ready, 1);
        chk("post_res_valid", res_valid, 0);
        chk("post_done", done_count, m_done);
        chk("post_err", err_count, m_err);
        chk("post_res_data", res_data, m_last_res);
        req_valid = 1'b0;
        res_ready = 1'b0;
        rsp_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        chk("rw_req_ready", req_ready, 1);
        req_valid    = 1'b1;
        req_inputs_0 = $urandom;
        req_inputs_1 = $urandom;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        @(negedge clk);
        chk("rw_issue", cmd_valid, 1);
        req_valid = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk);
        chk("rw_wait_cmd_valid", cmd_valid, 0);
        chk("rw_wait_req_ready", req_ready, 0);
        cmd_ready = 1'b0;
        @(negedge clk);
        chk("rw_wait2_res_valid", res_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state();
        m_done     = 0;
        m_err      = 0;
        m_last_res = 0;
    endtask

    initial begin
        reset                 = 1'b1;
        req_valid             = 1'b0;
        req_function_id       = '0;
        req_state_id          = '0;
        req_cxu_id            = '0;
        req_inputs_0          = '0;
        req_inputs_1          = '0;
        cmd_ready             = 1'b0;
        rsp_valid             = 1'b0;
        rsp_payload_outputs_0 = '0;
        res_ready             = 1'b0;
        m_done                = 0;
        m_err                 = 0;
        m_last_res            = 0;

        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        run_txn(1, 0, 1'b1, 32'd3, 32'd5);
        chk("mult_result", m_last_res, 32'd15);
        chk("mult_done", done_count, 16'd1);
        run_txn(2, 0, 1'b0, '0, '0);
        chk("stall_result", res_data, 32'hDEADBEEF);
        run_txn(3, 2, 1'b0, '0, '0);
        idle_cycles(4);
        run_txn(0, 10, 1'b0, '0, '0);
        run_txn(4, 1, 1'b0, '0, '0);
        reset_in_wait();
        run_txn(1, 0, 1'b0, '0, '0);
        run_txn(3, 0, 1'b0, '0, '0);
        for (int i = 0; i < 40; i++) begin
            idle_cycles($urandom_range(0, 2));
            run_txn(0, $urandom_range(0, 3), 1'b0, '0, '0);
        end
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
